// File: rtl/ita_activation.sv
// N-lane, 3-stage i-GELU / ReLU / identity activation pipeline with valid/ready flow control.
// Optional per-beat requantisation of the lane results is enabled by defining ITA_ACT_REQUANT_EN.
module ita_activation #(
    parameter int unsigned N                    = 16,
    parameter int unsigned WI                   = 8,
    parameter int unsigned GELU_CONSTANTS_WIDTH = 16,
    parameter int unsigned GELU_OUT_WIDTH       = 26,
    parameter int unsigned CW                   = GELU_CONSTANTS_WIDTH,
    parameter int unsigned OW                   = GELU_OUT_WIDTH,
`ifdef ITA_ACT_REQUANT_EN
    parameter int unsigned DW                   = WI
`else
    parameter int unsigned DW                   = OW
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [1:0]           mode_i,
    input  logic signed [CW-1:0] one_i,
    input  logic signed [CW-1:0] b_i,
    input  logic signed [CW-1:0] c_i,
`ifdef ITA_ACT_REQUANT_EN
    input  logic [7:0]           mult_i,
    input  logic [4:0]           shift_i,
    input  logic signed [WI-1:0] add_i,
`endif
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [N*WI-1:0]      data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [N*DW-1:0]      data_o,
    output logic [1:0]           occupancy_o
);

    typedef enum logic [1:0] {
        MODE_IDENT0 = 2'b00,
        MODE_RELU   = 2'b01,
        MODE_GELU   = 2'b10,
        MODE_IDENT1 = 2'b11
    } mode_e;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    // Stage 1 registers: sampled beat plus the per-beat configuration that travels with it.
    mode_e                 s1_mode;
    logic signed [CW-1:0]  s1_one;
    logic signed [CW-1:0]  s1_c;
    logic [N-1:0]          s1_sgn;
    logic signed [WI-1:0]  s1_x [N];
    logic signed [CW-1:0]  s1_d [N];

    // Stage 2 registers
    mode_e                 s2_mode;
    logic signed [WI-1:0]  s2_x   [N];
    logic signed [OW-1:0]  s2_sum [N];

`ifdef ITA_ACT_REQUANT_EN
    logic [7:0]            s1_mult,  s2_mult;
    logic [4:0]            s1_shift, s2_shift;
    logic signed [WI-1:0]  s1_add,   s2_add;
`endif

    logic [N-1:0]          st1_sgn;
    logic signed [CW-1:0]  st1_d   [N];
    logic signed [OW-1:0]  st2_sum [N];
    logic signed [OW-1:0]  st3_r   [N];
    logic [N*DW-1:0]       st3_out;

    assign adv3        = !v3 || ready_i;
    assign adv2        = !v2 || adv3;
    assign adv1        = !v1 || adv2;
    assign ready_o     = rst_ni && !clear_i && adv1;
    assign valid_o     = v3;
    assign occupancy_o = 2'(v1) + 2'(v2) + 2'(v3);

    // Stage 1: sign, absolute value, clip to -b and offset by b.
    always_comb begin
        logic signed [CW-1:0] xe, absx, negb, clip;
        st1_sgn = '0;
        for (int unsigned i = 0; i < N; i++) begin
            xe         = CW'($signed(data_i[i*WI +: WI]));
            absx       = (xe < 0) ? -xe : xe;
            negb       = -b_i;
            clip       = (absx < negb) ? absx : negb;
            st1_sgn[i] = (xe < 0);
            st1_d[i]   = clip + b_i;
        end
    end

    // Stage 2: erf polynomial and offset, all modulo OW.
    always_comb begin
        logic signed [OW-1:0] de, erfl, erf;
        for (int unsigned i = 0; i < N; i++) begin
            de         = OW'(s1_d[i]);
            erfl       = de * de + OW'(s1_c);
            erf        = s1_sgn[i] ? -erfl : erfl;
            st2_sum[i] = erf + OW'(s1_one);
        end
    end

    // Stage 3: mode select, then optional requantisation.
    always_comb begin
        logic signed [OW-1:0] xo;
        st3_out = '0;
        for (int unsigned i = 0; i < N; i++) begin
            xo = OW'(s2_x[i]);
            unique case (s2_mode)
                MODE_GELU: st3_r[i] = xo * s2_sum[i];
                MODE_RELU: st3_r[i] = (xo < 0) ? '0 : xo;
                default:   st3_r[i] = xo;
            endcase
`ifndef ITA_ACT_REQUANT_EN
            st3_out[i*DW +: DW] = st3_r[i];
`endif
        end
    end

`ifdef ITA_ACT_REQUANT_EN
    // Wide enough for r*mult plus a rounding term of up to 2^30.
    localparam int unsigned PW = (OW + 10 > 33) ? OW + 10 : 33;
    localparam logic signed [PW-1:0] YMAX = PW'((2 ** (WI - 1)) - 1);
    localparam logic signed [PW-1:0] YMIN = PW'(-(2 ** (WI - 1)));

    always_comb begin
        logic signed [PW-1:0] prod, rnd, q, y;
        logic signed [WI-1:0] ys;
        for (int unsigned i = 0; i < N; i++) begin
            prod = PW'(st3_r[i]) * PW'($signed({1'b0, s2_mult}));
            rnd  = (s2_shift != 5'd0) ? (PW'(1) <<< (s2_shift - 5'd1)) : '0;
            q    = (prod + rnd) >>> s2_shift;
            y    = q + PW'(s2_add);
            if (y > YMAX)      ys = YMAX[WI-1:0];
            else if (y < YMIN) ys = YMIN[WI-1:0];
            else               ys = y[WI-1:0];
            st3_out[i*DW +: DW] = ys;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            data_o <= '0;
        end else if (clear_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= valid_i;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
            if (adv3 && v2) data_o <= st3_out;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv1) begin
            s1_mode <= mode_e'(mode_i);
            s1_one  <= one_i;
            s1_c    <= c_i;
            s1_sgn  <= st1_sgn;
`ifdef ITA_ACT_REQUANT_EN
            s1_mult  <= mult_i;
            s1_shift <= shift_i;
            s1_add   <= add_i;
`endif
            for (int unsigned i = 0; i < N; i++) begin
                s1_x[i] <= $signed(data_i[i*WI +: WI]);
                s1_d[i] <= st1_d[i];
            end
        end
        if (adv2) begin
            s2_mode <= s1_mode;
`ifdef ITA_ACT_REQUANT_EN
            s2_mult  <= s1_mult;
            s2_shift <= s1_shift;
            s2_add   <= s1_add;
`endif
            for (int unsigned i = 0; i < N; i++) begin
                s2_x[i]   <= s1_x[i];
                s2_sum[i] <= st2_sum[i];
            end
        end
    end

endmodule

// File: tb/tb_ita_activation.sv
// Scoreboard bench for ita_activation: driver pushes hand-computed expectations, monitor pops on each emitted beat.
// Define ITA_ACT_REQUANT_EN for both files to exercise the requantised output path.
module tb_ita_activation;

    localparam int unsigned N  = 4;
    localparam int unsigned WI = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned OW = 26;
`ifdef ITA_ACT_REQUANT_EN
    localparam int unsigned DW = WI;
`else
    localparam int unsigned DW = OW;
`endif

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 clear_i = 1'b0;
    logic [1:0]           mode_i = 2'b00;
    logic signed [CW-1:0] one_i = 16'sd484;
    logic signed [CW-1:0] b_i = -16'sd22;
    logic signed [CW-1:0] c_i = -16'sd484;
    logic [7:0]           mult_i = 8'd1;
    logic [4:0]           shift_i = 5'd0;
    logic signed [WI-1:0] add_i = '0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [N*WI-1:0]      data_i = '0;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic [N*DW-1:0]      data_o;
    logic [1:0]           occupancy_o;

    ita_activation #(.N(N), .WI(WI), .GELU_CONSTANTS_WIDTH(CW), .GELU_OUT_WIDTH(OW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .mode_i(mode_i),
        .one_i(one_i), .b_i(b_i), .c_i(c_i),
`ifdef ITA_ACT_REQUANT_EN
        .mult_i(mult_i), .shift_i(shift_i), .add_i(add_i),
`endif
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N*DW-1:0] data;
        int              at;
        bit              lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [N*WI-1:0] pin(input int a, input int b, input int c, input int d);
        int v[4];
        logic [N*WI-1:0] r;
        v = '{a, b, c, d};
        r = '0;
        for (int i = 0; i < 4; i++) r[i*WI +: WI] = WI'(v[i]);
        return r;
    endfunction

    // Raw lane results; with requant enabled and unity scaling they appear saturated to WI bits.
    function automatic logic [N*DW-1:0] pout(input int a, input int b, input int c, input int d);
        int v[4];
        logic [N*DW-1:0] r;
        v = '{a, b, c, d};
        r = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef ITA_ACT_REQUANT_EN
            if (v[i] > 127) v[i] = 127;
            if (v[i] < -128) v[i] = -128;
`endif
            r[i*DW +: DW] = DW'(v[i]);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no beat", data_o);
            end else begin
                e = sb.pop_front();
                chk("data_o", 128'(data_o), 128'(e.data));
                if (e.lat) chk("latency", 128'(cyc), 128'(e.at));
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [N*WI-1:0] x, input logic [N*DW-1:0] ex,
                        input bit lat, input logic [7:0] mu, input logic [4:0] sh, input logic [WI-1:0] ad);
        bit done;
        done = 1'b0;
        valid_i = 1'b1;
        mode_i = m;
        data_i = x;
        mult_i = mu;
        shift_i = sh;
        add_i = ad;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back('{ex, cyc + 3, lat});
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready_o stayed 0 expected 1");
        end
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain;
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [N*DW-1:0] hold;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(ready_o), 128'(0));
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_occ", 128'(occupancy_o), 128'(0));
        chk("rst_data", 128'(data_o), 128'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_ready", 128'(ready_o), 128'(1));
        @(posedge clk);
        #1;

        // GELU reference vector and clip boundaries
        send(2'b10, pin(0, 10, -10, 7), pout(0, 1440, -8240, 1575), 1'b1, 8'd1, 5'd0, 8'd0);
        idle(4);
        send(2'b10, pin(127, -128, 30, -30), pout(0, -123904, 0, -29040), 1'b1, 8'd1, 5'd0, 8'd0);
        idle(4);

        // ReLU, both identity encodings, and mode changing every beat back to back
        send(2'b01, pin(-5, 7, 0, -128), pout(0, 7, 0, 0), 1'b1, 8'd1, 5'd0, 8'd0);
        send(2'b00, pin(-128, 127, -1, 5), pout(-128, 127, -1, 5), 1'b1, 8'd1, 5'd0, 8'd0);
        send(2'b10, pin(0, 10, -10, 7), pout(0, 1440, -8240, 1575), 1'b1, 8'd1, 5'd0, 8'd0);
        send(2'b11, pin(3, -3, 100, -100), pout(3, -3, 100, -100), 1'b1, 8'd1, 5'd0, 8'd0);
        send(2'b01, pin(-1, 1, 127, -127), pout(0, 1, 127, 0), 1'b1, 8'd1, 5'd0, 8'd0);
        idle(5);
        drain();

`ifdef ITA_ACT_REQUANT_EN
        send(2'b10, pin(10, -10, 0, 7), pout(73, -128, 5, 79), 1'b1, 8'd3, 5'd6, 8'd5);
        idle(5);
        drain();
`endif

        // Backpressure: 6-beat stream, output held off for 5 cycles after the first valid_o
        ready_i = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(2'b00, pin(k, -k, 10 * k, 0), pout(k, -k, 10 * k, 0), 1'b0, 8'd1, 5'd0, 8'd0);
                valid_i = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    if (valid_o) seen = 1'b1;
                end
                chk("stall_seen", 128'(seen), 128'(1));
                hold = data_o;
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stall_occ", 128'(occupancy_o), 128'(3));
                    chk("stall_ready", 128'(ready_o), 128'(0));
                    chk("stall_valid", 128'(valid_o), 128'(1));
                    chk("stall_data", 128'(data_o), 128'(hold));
                    @(posedge clk);
                end
                #1;
                ready_i = 1'b1;
            end
        join
        idle(2);
        drain();

        // Clear with a simultaneous input beat
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++)
            send(2'b01, pin(k, k, k, k), pout(k, k, k, k), 1'b0, 8'd1, 5'd0, 8'd0);
        valid_i = 1'b1;
        data_i = pin(99, 99, 99, 99);
        clear_i = 1'b1;
        @(negedge clk);
        chk("clr_occ_before", 128'(occupancy_o), 128'(3));
        ready_i = 1'b1;
        #1;
        chk("clr_ready", 128'(ready_o), 128'(0));
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("clr_valid", 128'(valid_o), 128'(0));
        chk("clr_occ", 128'(occupancy_o), 128'(0));
        @(posedge clk);
        #1;
        send(2'b10, pin(10, 0, -10, 7), pout(1440, 0, -8240, 1575), 1'b1, 8'd1, 5'd0, 8'd0);
        idle(5);
        drain();

        // Reset mid-stream with beats in flight
        send(2'b00, pin(1, 2, 3, 4), pout(1, 2, 3, 4), 1'b0, 8'd1, 5'd0, 8'd0);
        send(2'b00, pin(5, 6, 7, 8), pout(5, 6, 7, 8), 1'b0, 8'd1, 5'd0, 8'd0);
        valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mrst_ready", 128'(ready_o), 128'(0));
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mrst_valid", 128'(valid_o), 128'(0));
        chk("mrst_occ", 128'(occupancy_o), 128'(0));
        chk("mrst_ready", 128'(ready_o), 128'(1));
        idle(6);
        send(2'b01, pin(-9, 9, -9, 9), pout(0, 9, 0, 9), 1'b1, 8'd1, 5'd0, 8'd0);
        idle(5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_activation.md
ITA_ACTIVATION -- requirements
Module: ita_activation

Interface
REQ-001 SHALL have parameter N, default 16, number of parallel lanes.
REQ-002 SHALL have parameter CW, default GELU_CONSTANTS_WIDTH, width of the GELU constants and internal absolute/clip path.
REQ-003 SHALL have parameter OW, default GELU_OUT_WIDTH, width of the raw activation result.
REQ-004 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock, synchronous, active-low.
- clear_i  in  1  synchronous flush of all in-flight beats.
- mode_i  in  2  activation select: 00 identity, 01 ReLU, 10 GELU, 11 identity.
- one_i / b_i / c_i  in  CW each  signed GELU constants.
- valid_i / ready_o  in / out  1 each  input handshake.
- data_i  in  N*WI  signed lane inputs, lane 0 in the LSBs.
- valid_o / ready_i  out / in  1 each  output handshake.
- data_o  out  N*OW, or N*WI when ITA_ACT_REQUANT_EN is defined  lane results.
- occupancy_o  out  2  number of valid pipeline stages, 0..3.

Function
REQ-005 SHALL sample mode_i, one_i, b_i and c_i with each accepted beat; the sampled values SHALL travel with that beat, so a change mid-stream affects only later beats.
REQ-006 SHALL accept a beat when valid_i && ready_o.
- Beat leaves when valid_o && ready_i.
REQ-007 SHALL implement a 3-stage pipeline; with ready_i held high, a beat accepted in cycle t SHALL appear on valid_o/data_o in cycle t+3.
REQ-008 SHALL sustain one beat per cycle when ready_i is high.
REQ-009 Each stage SHALL advance when it is empty or the stage downstream advances.
- ready_o = !v1 || adv1, computed combinationally.
- No bubble insertion on stall release.
REQ-010 While valid_o && !ready_i, data_o and valid_o SHALL remain stable.
REQ-011 Stage 1 SHALL sign-extend x to CW and compute sgn = x<0, abs = |x|, clip = min(abs, -b), d = clip + b.
REQ-012 Stage 2 SHALL compute the remaining GELU intermediate terms.
- erfL = d*d + c.
- erf = sgn ? -erfL : erfL.
- sum = erf + one.
REQ-013 Stage 3 SHALL compute the lane result:
- GELU: x*sum.
- ReLU: max(x,0).
- Identity: x.
- All results sign-extended to OW.
REQ-014 All GELU arithmetic SHALL be two's-complement modulo OW.
- Bit-exact to the single-cycle combinational i-GELU formula above; overflow wraps, no saturation.
REQ-015 Lanes SHALL be fully independent and share the handshake.
REQ-016 clear_i SHALL invalidate all stages at the next edge.
- ready_o SHALL be 0 while clear_i is high, so no beat is accepted in that cycle.
- valid_o SHALL be 0 from the next cycle.
- clear_i SHALL win over simultaneous valid_i/ready_i.
REQ-017 occupancy_o SHALL equal v1+v2+v3 after each edge.
- Simultaneous accept and emit SHALL leave it unchanged.

Reset
REQ-018 On a clk_i edge with rst_ni low, all stage valid bits SHALL clear: valid_o=0, occupancy_o=0.
REQ-019 ready_o SHALL be 0 while rst_ni is low and SHALL be 1 in the first cycle after release.
REQ-020 data_o SHALL reset to 0.
- Data pipeline registers need not reset otherwise.
REQ-021 Reset asserted mid-operation SHALL discard in-flight beats with no partial output.

Configuration
REQ-022 With ITA_ACT_REQUANT_EN defined, the block SHALL add the following inputs, sampled with each beat:
- mult_i: 8-bit unsigned.
- shift_i: 5-bit.
- add_i: WI-bit signed.
REQ-023 With ITA_ACT_REQUANT_EN defined, each lane result r SHALL be requantised in stage 3, latency unchanged:
- y = ((r*mult + (shift>0 ? 1<<(shift-1) : 0)) >>> shift) + add.
- y saturated to [-2^(WI-1), 2^(WI-1)-1].
- y output as WI bits.
REQ-024 Without ITA_ACT_REQUANT_EN, the requant ports SHALL be absent and data_o SHALL carry raw OW-bit results.

Verification
REQ-025 GELU, one=484, b=-22, c=-484, lanes x=0/10/-10, ready_i=1 -> data_o lanes 0/1440/-8240, valid_o exactly 3 cycles after accept.
REQ-026 mode=01, x=-5/7 -> 0/7; mode=00 (identity), x=-128 -> -128 sign-extended; mode switched every beat -> each beat uses its own mode.
REQ-027 Requant (ITA_ACT_REQUANT_EN), GELU x=10, mult=3, shift=6, add=5 -> 73; x=-10 -> saturates to -128.
REQ-028 Stream 6 beats, ready_i=0 for 5 cycles after first valid_o:
- ready_o drops once occupancy_o=3.
- data_o stable during the stall.
- After release, all 6 beats emerge in order, no loss or duplication.
REQ-029 Fill with 3 beats, assert clear_i together with valid_i:
- The simultaneous input beat is not accepted.
- valid_o=0 and occupancy_o=0 next cycle.
- The next accepted beat emerges after 3 cycles.
REQ-030 Pull rst_ni low for one cycle mid-stream -> valid_o=0, occupancy_o=0, ready_o=1 after release, no stale output.
